ahb_slave_interface: RTL



---
 rtl/ahb_apb_pkg.sv | 53 +++++
 rtl/ahb_addr_decode.sv | 32 +++
 rtl/ahb_slave_interface.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_pkg
// Shared encodings for the AHB-to-APB bridge front end:
//   - HTRANS / HBURST / HRESP encodings
//   - error-response state enum
//   - default peripheral base addresses and the 64 MB region mask
//   - burst_beats_init(): beats still to come after the NONSEQ of a fixed burst
// ---------------------------------------------------------------------------
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   // Two-cycle AHB ERROR response sequencer.
   typedef enum logic [1:0] {
      ERR_OK = 2'b00,
      ERR_1  = 2'b01,
      ERR_2  = 2'b10
   } err_state_t;

   localparam logic [31:0] DEFAULT_BASE0 = 32'h8000_0000;
   localparam logic [31:0] DEFAULT_BASE1 = 32'h8400_0000;
   localparam logic [31:0] DEFAULT_BASE2 = 32'h8800_0000;

   // Each peripheral owns a 64 MB window, so only haddr[31:26] selects it.
   localparam logic [31:0] REGION_MASK = 32'hFC00_0000;

   // Beats remaining after the NONSEQ beat; undefined-length INCR and
   // SINGLE both start at 0.
   function automatic logic [3:0] burst_beats_init(input logic [2:0] hburst);
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  burst_beats_init = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  burst_beats_init = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: burst_beats_init = 4'd15;
         default:                      burst_beats_init = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// ---------------------------------------------------------------------------
// ahb_addr_decode
// Combinational APB peripheral select decode.
// Ports:
//   haddr    in  32  AHB address-phase address
//   tempselx out 3   one-hot peripheral select (000 when unmapped)
//   mapped   out 1   address hits one of the three regions
// ---------------------------------------------------------------------------
module ahb_addr_decode
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] BASE0 = DEFAULT_BASE0,
   parameter logic [31:0] BASE1 = DEFAULT_BASE1,
   parameter logic [31:0] BASE2 = DEFAULT_BASE2
) (
   input  logic [31:0] haddr,
   output logic [2:0]  tempselx,
   output logic        mapped
);

   always_comb begin
      // NOTE: every output gets a default first so no path through this
      // block leaves a value unassigned, which would infer a latch.
      tempselx = 3'b000;
      if ((haddr & REGION_MASK) == (BASE0 & REGION_MASK)) tempselx[0] = 1'b1;
      if ((haddr & REGION_MASK) == (BASE1 & REGION_MASK)) tempselx[1] = 1'b1;
      if ((haddr & REGION_MASK) == (BASE2 & REGION_MASK)) tempselx[2] = 1'b1;
   end

   assign mapped = |tempselx;

endmodule

// File: rtl/ahb_slave_interface.sv
// ---------------------------------------------------------------------------
// ahb_slave_interface
// AHB-facing front stage of the AHB-to-APB bridge. Qualifies transfers,
// decodes the peripheral select, pipelines address/data/direction two deep,
// tracks fixed-burst beats and generates the two-cycle ERROR response.
// Ports:
//   hclk, hresetn          clock, async active-low reset
//   hselapb, hreadyin      slave select, AHB HREADY
//   htrans, hburst, hsize  transfer type, burst type, size
//   hwrite, haddr, hwdata  direction, address, write data
//   valid                  qualified transfer (combinational)
//   tempselx               one-hot peripheral select (combinational)
//   haddr1/2, hwdata1/2    address and write-data pipelines
//   hwrite_reg             registered hwrite
//   burst_last             final beat of a fixed burst or SINGLE
//   hresp, err_busy        ERROR response; err_busy stalls HREADYOUT
// ---------------------------------------------------------------------------
module ahb_slave_interface
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] BASE0 = DEFAULT_BASE0,
   parameter logic [31:0] BASE1 = DEFAULT_BASE1,
   parameter logic [31:0] BASE2 = DEFAULT_BASE2
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hselapb,
   input  logic        hreadyin,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hburst,
   input  logic [2:0]  hsize,
   input  logic        hwrite,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   output logic        valid,
   output logic [2:0]  tempselx,
   output logic [31:0] haddr1,
   output logic [31:0] haddr2,
   output logic [31:0] hwdata1,
   output logic [31:0] hwdata2,
   output logic        hwrite_reg,
   output logic        burst_last,
   output logic [1:0]  hresp,
   output logic        err_busy
);

   err_state_t  err_state;
   logic [3:0]  beats_left;
   logic        mapped;
   logic        xfer;
   logic        seq_violation;
   logic        bad;
   logic        is_nonseq;
   logic        is_seq;

   ahb_addr_decode #(
      .BASE0 (BASE0),
      .BASE1 (BASE1),
      .BASE2 (BASE2)
   ) u_decode (
      .haddr    (haddr),
      .tempselx (tempselx),
      .mapped   (mapped)
   );

   assign is_nonseq = (htrans == HTRANS_NONSEQ);
   assign is_seq    = (htrans == HTRANS_SEQ);

   // htrans[1] covers NONSEQ and SEQ; BUSY and IDLE are never qualified.
   assign xfer = hselapb & hreadyin & htrans[1];

   // A SEQ beat with nothing left to transfer overruns a fixed burst.
   assign seq_violation = is_seq & (beats_left == 4'd0) & (hburst != HBURST_INCR);

   assign bad   = xfer & (~mapped | (hsize > 3'd2) | seq_violation);
   assign valid = xfer & ~bad & (err_state == ERR_OK);

   assign burst_last = valid & ((is_nonseq & (hburst == HBURST_SINGLE)) |
                                (is_seq & (beats_left == 4'd1)));

   assign hresp    = (err_state == ERR_OK) ? HRESP_OKAY : HRESP_ERROR;
   assign err_busy = (err_state == ERR_1);

   // Address / data / direction pipeline, frozen while the bus is stalled.
   always_ff @(posedge hclk or negedge hresetn) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // haddr2 picks up the old haddr1, not the value updated this edge.
      if (!hresetn) begin
         // NOTE: every register here is reset explicitly; the downstream
         // controller may look at the pipeline before the first transfer.
         haddr1     <= '0;
         haddr2     <= '0;
         hwdata1    <= '0;
         hwdata2    <= '0;
         hwrite_reg <= 1'b0;
      end else if (hreadyin) begin
         haddr1     <= haddr;
         haddr2     <= haddr1;
         hwdata1    <= hwdata;
         hwdata2    <= hwdata1;
         hwrite_reg <= hwrite;
      end
   end

   // Burst beat tracker. Starting an error response abandons the burst.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         beats_left <= 4'd0;
      end else if ((err_state == ERR_OK) && bad) begin
         beats_left <= 4'd0;
      end else if (valid) begin
         if (is_nonseq) begin
            beats_left <= burst_beats_init(hburst);
         end else if (beats_left != 4'd0) begin
            beats_left <= beats_left - 4'd1;
         end
      end
   end

   // Two-cycle ERROR: cycle 1 stalls HREADYOUT, cycle 2 releases it.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         err_state <= ERR_OK;
      end else begin
         case (err_state)
            ERR_OK:  if (bad) err_state <= ERR_1;
            ERR_1:   err_state <= ERR_2;
            default: err_state <= ERR_OK;
         endcase
      end
   end

endmodule
